ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
// Issues one word fetch at a time to instruction memory and queues the returned
// words with their fetch addresses in a two-entry FIFO for decode. A redirect
// flushes the FIFO and drops any response still in flight.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect flag).
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [6:0]  inst_opcode,
  output logic        misalign_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;  // no request outstanding
  localparam logic [1:0] ST_WAIT  = 2'd1;  // request outstanding, response will be kept
  localparam logic [1:0] ST_DRAIN = 2'd2;  // request outstanding, response will be dropped

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_pc_d   [2];
  logic [31:0] fifo_data_q [2];
  logic [31:0] fifo_data_d [2];

  logic        accept;
  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  count_after;
  logic [31:0] redirect_target;

  // Redirect targets are always word aligned; the low two bits are discarded.
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Handshake terms: response acceptance, FIFO push/pop and the issue decision.
  always_comb begin
    accept      = (state_q == ST_WAIT) && imem_rvalid;
    push        = accept && !redirect_valid;
    pop         = (count_q != 2'd0) && inst_ready && !redirect_valid;
    count_after = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    // A new fetch only goes out when the FIFO will still have room for its
    // response after this cycle's push/pop; rst_n keeps imem_req low in reset.
    issue       = rst_n && !redirect_valid &&
                  ((state_q == ST_IDLE) || accept) &&
                  (count_after < 3'd2);
  end

  // Next-state logic for the fetch FSM, fetch PC and FIFO.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    fifo_pc_d[0]   = fifo_pc_q[0];
    fifo_pc_d[1]   = fifo_pc_q[1];
    fifo_data_d[0] = fifo_data_q[0];
    fifo_data_d[1] = fifo_data_q[1];

    if (redirect_valid) begin
      // Redirect wins over push, pop and issue: flush and restart from target.
      fetch_pc_d = redirect_target;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      case (state_q)
        // A response arriving this very cycle retires the old request, so
        // there is nothing left to drain; otherwise wait for it and drop it.
        ST_WAIT, ST_DRAIN: state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
        default:           state_d = ST_IDLE;
      endcase
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        fifo_data_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_after[1:0];

      case (state_q)
        ST_IDLE:  state_d = issue ? ST_WAIT : ST_IDLE;
        ST_WAIT:  if (imem_rvalid) state_d = issue ? ST_WAIT : ST_IDLE;
        ST_DRAIN: if (imem_rvalid) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;  // wraps modulo 2^32
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      fetch_pc_q     <= RESET_PC;
      req_pc_q       <= RESET_PC;
      count_q        <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      fifo_pc_q[0]   <= 32'h0;
      fifo_pc_q[1]   <= 32'h0;
      fifo_data_q[0] <= 32'h0;
      fifo_data_q[1] <= 32'h0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      req_pc_q       <= req_pc_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      fifo_pc_q[0]   <= fifo_pc_d[0];
      fifo_pc_q[1]   <= fifo_pc_d[1];
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = (count_q != 2'd0);
  assign inst_data   = fifo_data_q[rd_ptr_q];
  assign inst_pc     = fifo_pc_q[rd_ptr_q];
  assign inst_opcode = inst_data[6:0];

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_err_q, misalign_err_d;

  // Sticky flag: any redirect with nonzero low address bits sets it until reset.
  always_comb begin
    misalign_err_d = misalign_err_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
  end

  // Flag register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

  assign misalign_err = misalign_err_q;
`else
  // Low redirect bits are deliberately ignored when the check is not built.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misalign_err         = 1'b0;
`endif

endmodule
